// File: rtl/alu_result_bcd.sv
// rtl/alu_result_bcd.sv - signed ALU result to sign + packed BCD via sequential double-dabble
module alu_result_bcd #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*WIDTH-1:0]    result,
  input  logic                  err_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic                  err,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int N  = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [N-1:0]    mag;
  logic [N-1:0]    mag_in;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   scratch_adj;
  logic [CW-1:0]   cnt;
  logic            sign_lat;
  logic            err_lat;

  // Magnitude of the incoming two's-complement value; the most-negative code maps onto itself
  // as an unsigned N-bit number, so no extra bit is needed.
  always_comb begin
    mag_in = result;
    if (result[N-1]) begin
      mag_in = (~result) + N'(1);
    end
  end

  // Add-3 correction applied to every BCD digit of 5 or more before each shift.
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic; busy is simply "not idle".
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = err_in ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(N - 1)) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Conversion datapath: capture on accept, shift one bit per edge, publish at FINISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag      <= '0;
      scratch  <= '0;
      cnt      <= '0;
      sign_lat <= 1'b0;
      err_lat  <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      err      <= 1'b0;
      bcd      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_lat <= result[N-1];
            err_lat  <= err_in;
            mag      <= mag_in;
            scratch  <= '0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          scratch <= {scratch_adj[BW-2:0], mag[N-1]};
          mag     <= {mag[N-2:0], 1'b0};
          cnt     <= cnt + CW'(1);
        end
        FINISH: begin
          sign <= sign_lat;
          err  <= err_lat;
          bcd  <= err_lat ? '0 : scratch;
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_bcd.sv
// tb/tb_alu_result_bcd.sv - directed self-checking bench for alu_result_bcd
module tb_alu_result_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] result;
  logic        err_in;
  logic        busy;
  logic        done;
  logic        sign;
  logic        err;
  logic [15:0] bcd;

  int total = 0;
  int bad   = 0;

  alu_result_bcd #(.WIDTH(6), .DIGITS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .result (result),
    .err_in (err_in),
    .busy   (busy),
    .done   (done),
    .sign   (sign),
    .err    (err),
    .bcd    (bcd)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one conversion at a falling edge and wait (bounded) for done.
  // On return the bench sits at the falling edge of the done cycle (or the timeout point).
  task automatic do_conv(input logic [11:0] r, input logic e, output int bc, output logic got);
    result = r;
    err_in = e;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc    = 0;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy === 1'b1) bc++;
      @(negedge clk);
    end
  endtask

  int   bc;
  logic got;
  int   dn;
  int   gap;
  logic pulsed;
  logic [15:0] bcd_at_done;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    result = '0;
    err_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sign", 32'(sign), 32'd0);
    check("reset_err",  32'(err),  32'd0);
    check("reset_bcd",  32'(bcd),  32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 123
    do_conv(12'h07B, 1'b0, bc, got);
    check("c123_got_done", 32'(got), 32'd1);
    check("c123_busy_cycles", 32'(bc), 32'd13);
    check("c123_busy_in_done", 32'(busy), 32'd0);
    check("c123_sign", 32'(sign), 32'd0);
    check("c123_err",  32'(err),  32'd0);
    check("c123_bcd",  32'(bcd),  32'h0123);
    @(negedge clk);
    check("c123_done_pulse", 32'(done), 32'd0);
    check("c123_bcd_hold", 32'(bcd), 32'h0123);

    // -123
    do_conv(12'hF85, 1'b0, bc, got);
    check("neg123_got_done", 32'(got), 32'd1);
    check("neg123_sign", 32'(sign), 32'd1);
    check("neg123_bcd",  32'(bcd),  32'h0123);
    @(negedge clk);

    // most negative
    do_conv(12'h800, 1'b0, bc, got);
    check("min_got_done", 32'(got), 32'd1);
    check("min_sign", 32'(sign), 32'd1);
    check("min_bcd",  32'(bcd),  32'h2048);
    @(negedge clk);

    // most positive
    do_conv(12'h7FF, 1'b0, bc, got);
    check("max_got_done", 32'(got), 32'd1);
    check("max_sign", 32'(sign), 32'd0);
    check("max_bcd",  32'(bcd),  32'h2047);
    @(negedge clk);

    // error path
    do_conv(12'h3A5, 1'b1, bc, got);
    check("err_got_done", 32'(got), 32'd1);
    check("err_busy_cycles", 32'(bc), 32'd1);
    check("err_err",  32'(err),  32'd1);
    check("err_bcd",  32'(bcd),  32'h0000);
    check("err_sign", 32'(sign), 32'd0);
    @(negedge clk);
    check("err_done_pulse", 32'(done), 32'd0);

    // start ignored while busy
    result = 12'h07B;
    err_in = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bc     = 0;
    dn     = 0;
    pulsed = 1'b0;
    bcd_at_done = '0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) bc++;
      if (done === 1'b1) begin
        dn++;
        bcd_at_done = bcd;
      end
      if (bc == 5 && !pulsed) begin
        pulsed = 1'b1;
        start  = 1'b1;
        result = 12'h010;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("ign_done_count", 32'(dn), 32'd1);
    check("ign_busy_cycles", 32'(bc), 32'd13);
    check("ign_bcd", 32'(bcd_at_done), 32'h0123);

    // back-to-back: start in the done cycle
    do_conv(12'hF85, 1'b0, bc, got);
    check("b2b_first_got", 32'(got), 32'd1);
    check("b2b_first_sign", 32'(sign), 32'd1);
    result = 12'h000;
    err_in = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap   = 1;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      gap++;
      @(negedge clk);
    end
    check("b2b_second_got", 32'(got), 32'd1);
    check("b2b_gap", 32'(gap), 32'd14);
    check("b2b_bcd",  32'(bcd),  32'h0000);
    check("b2b_sign", 32'(sign), 32'd0);
    @(negedge clk);

    // reset mid-operation
    do_conv(12'h800, 1'b0, bc, got);
    check("rst_pre_bcd", 32'(bcd), 32'h2048);
    @(negedge clk);
    result = 12'h07B;
    err_in = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc    = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) bc++;
      if (bc == 6) break;
      @(negedge clk);
    end
    check("rst_reached_cycle6", 32'(bc), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd),  32'h0);
    check("rst_sign", 32'(sign), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    check("rst_no_done", 32'(dn), 32'd0);

    do_conv(12'h064, 1'b0, bc, got);
    check("post_rst_got", 32'(got), 32'd1);
    check("post_rst_busy_cycles", 32'(bc), 32'd13);
    check("post_rst_bcd",  32'(bcd),  32'h0100);
    check("post_rst_sign", 32'(sign), 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
